// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared constants for the keypad entry controller; the display block decodes
// state_o with the same encodings.
package keypad_entry_ctrl_pkg;

  localparam logic [2:0] ENTER_A   = 3'd0;
  localparam logic [2:0] ENTER_B   = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] SHOW      = 3'd4;

  localparam logic [3:0] BCD_NONE = 4'b1111;

  localparam logic DB_WAIT_PRESS   = 1'b0;
  localparam logic DB_WAIT_RELEASE = 1'b1;

  function automatic logic is_bcd_digit(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_key_debounce.sv
// Turns the decoder's per-cycle key indication into one strobe per physical
// press, requiring DEBOUNCE_CYCLES stable cycles for both press and release.
module key_debounce
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_valid,
  input  logic [3:0] bcd,
  output logic       key_strobe,
  output logic [3:0] key_digit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             db_state_r, db_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       cand_r, cand_s;
  logic             strobe_r, strobe_s;
  logic [3:0]       digit_r, digit_s;
  logic             key_s;

  // Out-of-range codes (including BCD_NONE) count as no key.
  assign key_s = pad_valid && is_bcd_digit(bcd);

  // Debounce next-state: stability counting for press and release phases.
  always_comb begin
    db_state_s = db_state_r;
    cnt_s      = cnt_r;
    cand_s     = cand_r;
    strobe_s   = 1'b0;
    digit_s    = digit_r;
    case (db_state_r)
      DB_WAIT_PRESS: begin
        if (!key_s) begin
          cnt_s  = '0;
          cand_s = BCD_NONE;
        end else if (bcd != cand_r) begin
          cnt_s  = '0;
          cand_s = bcd;
        end else if (cnt_r == CNT_LAST) begin
          strobe_s   = 1'b1;
          digit_s    = cand_r;
          cnt_s      = '0;
          cand_s     = BCD_NONE;
          db_state_s = DB_WAIT_RELEASE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DB_WAIT_RELEASE: begin
        if (key_s) begin
          cnt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s      = '0;
          db_state_s = DB_WAIT_PRESS;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        db_state_s = DB_WAIT_PRESS;
        cnt_s      = '0;
        cand_s     = BCD_NONE;
      end
    endcase
  end

  // Debounce state and registered strobe/digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_state_r <= DB_WAIT_PRESS;
      cnt_r      <= '0;
      cand_r     <= BCD_NONE;
      strobe_r   <= 1'b0;
      digit_r    <= 4'd0;
    end else begin
      db_state_r <= db_state_s;
      cnt_r      <= cnt_s;
      cand_r     <= cand_s;
      strobe_r   <= strobe_s;
      digit_r    <= digit_s;
    end
  end

  assign key_strobe = strobe_r;
  assign key_digit  = digit_r;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad sequencer: collects two BCD operands from debounced key presses,
// launches the multiplier and holds the operands while the result is shown.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pad_valid,
  input  logic [3:0]          bcd,
  input  logic                mul_ready,
  input  logic                mul_done,
  output logic [4*DIGITS-1:0] op_a,
  output logic [4*DIGITS-1:0] op_b,
  output logic                mul_start,
  output logic                busy,
  output logic                result_valid,
  output logic                key_strobe,
  output logic [2:0]          digit_cnt,
  output logic [2:0]          state_o
);

  localparam int OP_W = 4 * DIGITS;
  localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

  logic            strobe_s;
  logic [3:0]      digit_s;
  logic [2:0]      state_r, state_s;
  logic [OP_W-1:0] op_a_r, op_b_r;
  logic [2:0]      digit_cnt_r;
  logic            last_digit_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .pad_valid (pad_valid),
    .bcd       (bcd),
    .key_strobe(strobe_s),
    .key_digit (digit_s)
  );

  assign last_digit_s = (digit_cnt_r == LAST_DIGIT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ENTER_A;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ENTER_A: begin
        if (strobe_s && last_digit_s) state_s = ENTER_B;
        else                          state_s = ENTER_A;
      end
      ENTER_B: begin
        if (strobe_s && last_digit_s) state_s = START;
        else                          state_s = ENTER_B;
      end
      START: begin
        if (mul_ready) state_s = WAIT_DONE;
        else           state_s = START;
      end
      WAIT_DONE: begin
        if (mul_done) state_s = SHOW;
        else          state_s = WAIT_DONE;
      end
      SHOW: begin
        if (strobe_s) state_s = ENTER_A;
        else          state_s = SHOW;
      end
      default: state_s = ENTER_A;
    endcase
  end

  // FSM outputs; mul_start is tied to the START->WAIT_DONE transition.
  always_comb begin
    mul_start    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_r)
      START: begin
        busy      = 1'b1;
        mul_start = mul_ready;
      end
      WAIT_DONE: busy = 1'b1;
      SHOW:      result_valid = 1'b1;
      default: begin
        mul_start    = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
      end
    endcase
  end

  // Operand shift registers and digit counter; the acknowledge key in SHOW clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r      <= '0;
      op_b_r      <= '0;
      digit_cnt_r <= 3'd0;
    end else begin
      case (state_r)
        ENTER_A: begin
          if (strobe_s) begin
            op_a_r      <= (op_a_r << 4'd4) | OP_W'(digit_s);
            digit_cnt_r <= last_digit_s ? 3'd0 : digit_cnt_r + 3'd1;
          end
        end
        ENTER_B: begin
          if (strobe_s) begin
            op_b_r      <= (op_b_r << 4'd4) | OP_W'(digit_s);
            digit_cnt_r <= last_digit_s ? 3'd0 : digit_cnt_r + 3'd1;
          end
        end
        SHOW: begin
          if (strobe_s) begin
            op_a_r      <= '0;
            op_b_r      <= '0;
            digit_cnt_r <= 3'd0;
          end
        end
        default: begin
          op_a_r      <= op_a_r;
          op_b_r      <= op_b_r;
          digit_cnt_r <= digit_cnt_r;
        end
      endcase
    end
  end

  assign op_a       = op_a_r;
  assign op_b       = op_b_r;
  assign digit_cnt  = digit_cnt_r;
  assign state_o    = state_r;
  assign key_strobe = strobe_s;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with DIGITS=2, DEBOUNCE_CYCLES=4.
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 2;
  localparam int DB     = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                pad_valid;
  logic [3:0]          bcd;
  logic                mul_ready;
  logic                mul_done;
  logic [4*DIGITS-1:0] op_a;
  logic [4*DIGITS-1:0] op_b;
  logic                mul_start;
  logic                busy;
  logic                result_valid;
  logic                key_strobe;
  logic [2:0]          digit_cnt;
  logic [2:0]          state_o;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int start_cnt = 0;
  int base_strobe;
  int base_start;

  keypad_entry_ctrl #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_valid   (pad_valid),
    .bcd         (bcd),
    .mul_ready   (mul_ready),
    .mul_done    (mul_done),
    .op_a        (op_a),
    .op_b        (op_b),
    .mul_start   (mul_start),
    .busy        (busy),
    .result_valid(result_valid),
    .key_strobe  (key_strobe),
    .digit_cnt   (digit_cnt),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe) strobe_cnt++;
    if (mul_start)  start_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] d, input int n);
    pad_valid = 1'b1;
    bcd       = d;
    step(n);
  endtask

  task automatic release_key(input int n);
    pad_valid = 1'b0;
    bcd       = 4'hF;
    step(n);
  endtask

  task automatic press(input logic [3:0] d);
    hold(d, 6);
    release_key(6);
  endtask

  initial begin
    rst       = 1'b1;
    pad_valid = 1'b0;
    bcd       = 4'hF;
    mul_ready = 1'b0;
    mul_done  = 1'b0;
    step(2);
    check("rst_op_a", 32'(op_a), 32'h0);
    check("rst_op_b", 32'(op_b), 32'h0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_key_strobe", 32'(key_strobe), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    rst = 1'b0;

    // Key 3 held 10 cycles, then released.
    base_strobe = strobe_cnt;
    hold(4'd3, 4);
    check("lat_early", 32'(key_strobe), 32'd0);
    step(1);
    check("lat_exact", 32'(key_strobe), 32'd1);
    step(1);
    check("strobe_single", 32'(key_strobe), 32'd0);
    step(4);
    release_key(6);
    check("held_one_strobe", 32'(strobe_cnt - base_strobe), 32'd1);
    check("op_a_03", 32'(op_a), 32'h03);
    check("digit_cnt_1", 32'(digit_cnt), 32'd1);

    // Bouncy key 7 never settles, then a steady hold.
    base_strobe = strobe_cnt;
    for (int i = 0; i < 4; i++) begin
      hold(4'd7, 3);
      release_key(1);
    end
    check("bounce_no_strobe", 32'(strobe_cnt - base_strobe), 32'd0);
    hold(4'd7, 5);
    release_key(6);
    check("steady_one_strobe", 32'(strobe_cnt - base_strobe), 32'd1);
    check("op_a_37", 32'(op_a), 32'h37);
    check("state_enter_b", 32'(state_o), 32'd1);
    check("digit_cnt_clr", 32'(digit_cnt), 32'd0);

    // Operand B with the multiplier initially not ready.
    press(4'd1);
    check("op_b_01", 32'(op_b), 32'h01);
    base_start = start_cnt;
    press(4'd2);
    check("op_b_12", 32'(op_b), 32'h12);
    check("state_start", 32'(state_o), 32'd2);
    check("busy_start", 32'(busy), 32'd1);
    check("no_start_unready", 32'(mul_start), 32'd0);
    step(5);
    check("start_wait_ready", 32'(start_cnt - base_start), 32'd0);
    check("state_start_hold", 32'(state_o), 32'd2);
    mul_ready = 1'b1;
    #1;
    check("mul_start_ready", 32'(mul_start), 32'd1);
    step(1);
    check("state_wait_done", 32'(state_o), 32'd3);
    check("mul_start_drop", 32'(mul_start), 32'd0);
    check("start_one_pulse", 32'(start_cnt - base_start), 32'd1);
    check("busy_wait", 32'(busy), 32'd1);

    // Key press in WAIT_DONE is ignored, late mul_done completes.
    base_strobe = strobe_cnt;
    press(4'd9);
    check("wait_strobe_seen", 32'(strobe_cnt - base_strobe), 32'd1);
    check("wait_state_hold", 32'(state_o), 32'd3);
    check("wait_op_b_stable", 32'(op_b), 32'h12);
    check("wait_op_a_stable", 32'(op_a), 32'h37);
    step(8);
    mul_done = 1'b1;
    step(1);
    mul_done = 1'b0;
    check("state_show", 32'(state_o), 32'd4);
    check("result_valid", 32'(result_valid), 32'd1);
    check("busy_show", 32'(busy), 32'd0);
    check("show_op_a", 32'(op_a), 32'h37);
    check("start_total", 32'(start_cnt - base_start), 32'd1);

    // Acknowledge press clears, then a fresh entry.
    press(4'd5);
    check("ack_op_a", 32'(op_a), 32'h0);
    check("ack_op_b", 32'(op_b), 32'h0);
    check("ack_state", 32'(state_o), 32'd0);
    check("ack_digit_cnt", 32'(digit_cnt), 32'd0);
    check("ack_result_valid", 32'(result_valid), 32'd0);
    press(4'd4);
    check("op_a_04", 32'(op_a), 32'h04);
    check("digit_cnt_after_ack", 32'(digit_cnt), 32'd1);

    // Reset during WAIT_DONE and a stray mul_done afterwards.
    press(4'd5);
    press(4'd6);
    press(4'd8);
    check("op_a_45", 32'(op_a), 32'h45);
    check("op_b_68", 32'(op_b), 32'h68);
    check("state_wait2", 32'(state_o), 32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_op_a", 32'(op_a), 32'h0);
    check("rst2_op_b", 32'(op_b), 32'h0);
    check("rst2_state", 32'(state_o), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_digit_cnt", 32'(digit_cnt), 32'd0);
    mul_done = 1'b1;
    step(1);
    mul_done = 1'b0;
    step(1);
    check("stray_done_state", 32'(state_o), 32'd0);
    check("stray_done_rv", 32'(result_valid), 32'd0);

    // Reset in the middle of a debounce restarts the count.
    base_strobe = strobe_cnt;
    hold(4'd2, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("db_rst_strobe", 32'(key_strobe), 32'd0);
    step(3);
    check("db_rst_restart", 32'(strobe_cnt - base_strobe), 32'd0);
    step(2);
    check("db_rst_strobe_late", 32'(key_strobe), 32'd1);
    release_key(6);
    check("db_rst_one_strobe", 32'(strobe_cnt - base_strobe), 32'd1);
    check("op_a_02", 32'(op_a), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequencer between the small-keypad BCD decoder and the Booth multiplier datapath. It debounces the decoder's per-cycle key indication and turns each physical press into exactly one digit event. It assembles two DIGITS-long BCD operands and launches the multiplier with a start/ready handshake. It holds the operands and flags result availability for the display path until the user presses a key again.

Parameters:
DIGITS, 2, BCD digits per operand (1..4)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a press or a release (>=1); benches override to 4
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pad_valid  in  1  decoder: a single legal key is held this cycle
bcd  in  4  decoder digit 0..9; 4'b1111 = no key
mul_ready  in  1  multiplier idle, can accept start
mul_done  in  1  multiplier single-cycle completion pulse
op_a  out  4*DIGITS  operand A, packed BCD, most significant digit in the top nibble
op_b  out  4*DIGITS  operand B, packed BCD, same layout
mul_start  out  1  single-cycle start pulse to the multiplier
busy  out  1  high in START and WAIT_DONE
result_valid  out  1  high in SHOW
key_strobe  out  1  single-cycle pulse per accepted digit
digit_cnt  out  3  digits entered into the current operand (0..DIGITS)
state_o  out  3  current FSM state encoding (debug and display)

Behaviour:
- Reset values: all outputs 0; op_a = op_b = 0; FSM in ENTER_A; debouncer in WAIT_PRESS with counter 0.
- Debouncer WAIT_PRESS:
  - pad_valid=1 with bcd equal to the previous cycle's bcd increments the counter.
  - pad_valid=0, or bcd changes, reloads the counter to 0. A changed bcd is captured as the new candidate.
  - When the counter reaches DEBOUNCE_CYCLES, assert key_strobe for 1 cycle with the candidate digit, then move to WAIT_RELEASE.
- Debouncer WAIT_RELEASE:
  - The counter counts consecutive pad_valid=0 cycles; any pad_valid=1 reloads it to 0.
  - At DEBOUNCE_CYCLES, return to WAIT_PRESS.
  - A held key therefore produces exactly one strobe.
- Minimum latency: key_strobe rises DEBOUNCE_CYCLES cycles after the first registered pad_valid cycle.
- FSM states: ENTER_A=0, ENTER_B=1, START=2, WAIT_DONE=3, SHOW=4.
- ENTER_A:
  - On key_strobe, op_a <= {op_a[4*DIGITS-5:0], digit} and digit_cnt increments.
  - The DIGITS-th strobe moves to ENTER_B and clears digit_cnt in the same edge.
- ENTER_B: identical behaviour on op_b; the DIGITS-th strobe moves to START.
- START:
  - Strobes are ignored.
  - When mul_ready=1, assert mul_start for exactly 1 cycle and move to WAIT_DONE.
  - While mul_ready=0, stay in START with mul_start=0.
- WAIT_DONE:
  - mul_done=1 moves to SHOW.
  - Strobes are ignored.
  - op_a and op_b stay stable from mul_start through the end of SHOW.
- SHOW:
  - result_valid=1.
  - The first key_strobe clears op_a, op_b and digit_cnt and returns to ENTER_A. That digit is consumed as an acknowledge and is not entered.
- mul_done outside WAIT_DONE is ignored.
- mul_start is never asserted outside the START->WAIT_DONE transition.
- Reset asserted in any state, including mid-debounce or WAIT_DONE, forces the reset values on the next edge. The multiplier is not notified.
- Digit value 0 is a legal entry. The controller never produces a nibble above 9. A bcd=4'b1111 with pad_valid=1 is treated as pad_valid=0.

Decomposition:
- Shared package: FSM state localparams (ENTER_A..SHOW) and the BCD_NONE=4'b1111 constant. The display block decodes state_o with the same package.
- One sub-module, key_debounce (clk, rst, pad_valid, bcd -> key_strobe, key_digit), parameterised by DEBOUNCE_CYCLES.
- The FSM and operand registers stay in keypad_entry_ctrl.

Test Plan:
- Reset, DIGITS=2, DEBOUNCE_CYCLES=4; hold key 3 for 10 cycles then release 6 cycles -> exactly one key_strobe; op_a=8'h03; digit_cnt=1.
- Key 7 held with 1-cycle dropouts every 3 cycles -> no strobe. Then steady for 5 cycles -> one strobe; op_a=8'h37; state ENTER_B; digit_cnt=0.
- Enter 1, 2 with mul_ready=0 for 5 cycles then 1 -> op_b=8'h12; mul_start a single pulse on the first mul_ready=1 cycle; busy=1.
- In WAIT_DONE, press key 9 and pulse mul_done 20 cycles later -> op_b unchanged; result_valid=1 the cycle after mul_done.
- In SHOW, press key 5 -> op_a=op_b=0, state ENTER_A, digit_cnt=0. The next press of 4 gives op_a=8'h04.
- Assert rst for 1 cycle during WAIT_DONE and mid-debounce -> all outputs 0, state ENTER_A. A stray mul_done after reset produces no transition.
